// File: rtl/bram_arb_pkg.sv
// Shared constants and types for the BRAM port-0 arbiter.
// Lock counter width bounds MAX_LOCK to 255.
package bram_arb_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;
  localparam int LOCK_W = 8;
  localparam int STAT_W = 16;

  typedef enum logic {
    ARB,
    LOCKED
  } arb_state_t;

endpackage

// File: rtl/bram_2048x8_port_arbiter_rr_pick.sv
// Round-robin priority picker: first set request at or after ptr,
// wrapping modulo N; returns one-hot grant and its index.
module rr_pick
  import bram_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx
);

  logic [PW:0] w_pos;
  logic        w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = {1'b0, i_ptr} + (PW+1)'(k);
      if (w_pos >= (PW+1)'(N)) begin
        w_pos = w_pos - (PW+1)'(N);
      end
      if (!w_found && i_req[w_pos[PW-1:0]]) begin
        w_found               = 1'b1;
        o_gnt[w_pos[PW-1:0]]  = 1'b1;
        o_idx                 = w_pos[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/bram_2048x8_port_arbiter.sv
// Round-robin arbiter with bounded locked bursts sharing BRAM port 0.
// Optional stall statistics enabled by BRAM_ARB_STATS_EN.
module bram_2048x8_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int MAX_LOCK = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ-1:0]          req_lock,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
`ifdef BRAM_ARB_STATS_EN
  input  logic [$clog2(NREQ)-1:0]  stat_sel,
  output logic [STAT_W-1:0]        stat_cnt,
`endif
  output logic [ADDR_W-1:0]        A0,
  output logic [DATA_W-1:0]        D0,
  output logic                     WE0,
  output logic [DATA_W-1:0]        WEM0,
  output logic                     CE0,
  input  logic [DATA_W-1:0]        Q0
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(MAX_LOCK);

  arb_state_t        r_state;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_owner;
  logic [LOCK_W-1:0] r_cnt;

  logic [ADDR_W-1:0] r_a0;
  logic [DATA_W-1:0] r_d0;
  logic              r_we0;
  logic              r_ce0;
  logic [NREQ-1:0]   r_tag1;
  logic [NREQ-1:0]   r_tag2;

  logic [NREQ-1:0]   w_gnt;
  logic [PW-1:0]     w_gidx;
  logic [NREQ-1:0]   w_ready;
  logic [PW-1:0]     w_idx;
  logic [PW-1:0]     w_ptr_nxt;
  logic [LOCK_W-1:0] w_cnt_nxt;
  logic              w_acc;
  logic              w_lock;
  logic              w_wr;

  rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_pick (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gidx)
  );

  always_comb begin
    w_ready = '0;
    w_idx   = w_gidx;
    if (r_state == LOCKED) begin
      w_idx            = r_owner;
      w_ready[r_owner] = req_valid[r_owner];
    end else begin
      w_ready = w_gnt;
    end
    if (RST) begin
      w_ready = '0;
    end
  end

  assign w_acc     = |w_ready;
  assign w_lock    = req_lock[w_idx];
  assign w_wr      = req_we[w_idx];
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_ptr_nxt = (w_idx == PW'(NREQ-1)) ? '0 : w_idx + 1'b1;

  // Every cycle spent LOCKED counts, so a burst never exceeds MAX_LOCK.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ARB;
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_acc) begin
        r_ptr <= w_ptr_nxt;
      end
      if (r_state == ARB) begin
        if (w_acc && w_lock && (MAX_LOCK > 1)) begin
          r_state <= LOCKED;
          r_owner <= w_idx;
          r_cnt   <= LOCK_W'(1);
        end
      end else begin
        if ((w_acc && !w_lock) || (w_cnt_nxt == LOCK_MAX)) begin
          r_state <= ARB;
          r_cnt   <= '0;
        end else begin
          r_cnt <= w_cnt_nxt;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_a0   <= '0;
      r_d0   <= '0;
      r_we0  <= 1'b0;
      r_ce0  <= 1'b0;
      r_tag1 <= '0;
      r_tag2 <= '0;
    end else begin
      r_ce0  <= w_acc;
      r_we0  <= w_acc && w_wr;
      if (w_acc) begin
        r_a0 <= req_addr[w_idx*ADDR_W +: ADDR_W];
        r_d0 <= req_wdata[w_idx*DATA_W +: DATA_W];
      end
      r_tag1 <= (w_acc && !w_wr) ? w_ready : '0;
      r_tag2 <= r_tag1;
    end
  end

  assign req_ready = w_ready;
  assign A0        = r_a0;
  assign D0        = r_d0;
  assign WE0       = r_we0;
  assign CE0       = r_ce0;
  assign WEM0      = '1;
  assign rsp_valid = r_tag2;
  assign rsp_rdata = Q0;

`ifdef BRAM_ARB_STATS_EN
  logic [STAT_W-1:0] r_stall [NREQ];
  logic [STAT_W-1:0] r_stat;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREQ; i++) begin
        r_stall[i] <= '0;
      end
      r_stat <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && !w_ready[i] && (r_stall[i] != '1)) begin
          r_stall[i] <= r_stall[i] + 1'b1;
        end
      end
      r_stat <= r_stall[stat_sel];
    end
  end

  assign stat_cnt = r_stat;
`endif

endmodule
